// File: rtl/tile_merge_engine.sv
// ---------------------------------------------------------------------------
// tile_merge_engine
//   Computes one 2048-style slide/merge move over a 4x4 board of exponent
//   cells, processing one line (row or column) per clock cycle.
//
//   Ports
//     clk        : single clock, all state updates on the rising edge
//     rst        : asynchronous active-high reset
//     start      : move request, accepted only while busy = 0
//     dir        : 00 left, 01 right, 10 up, 11 down
//     board_in   : board snapshot, cell (r,c) at bits [(r*4+c)*CELL_W +: CELL_W]
//     busy       : move in progress (from the cycle after acceptance to done)
//     done       : one-cycle pulse, results valid
//     board_out  : resulting board, same packing as board_in
//     moved      : board_out differs from the accepted board_in
//     score_add  : score gained by the move, saturating
//     win        : some board_out cell is >= WIN_EXP
//
//   Handshake: start is sampled on a rising edge while busy = 0; the move is
//   then accepted unconditionally. done pulses exactly once, five cycles after
//   acceptance, and results hold until the next done. Starts seen while busy
//   are dropped, nothing is queued.
// ---------------------------------------------------------------------------
module tile_merge_engine #(
    parameter int CELL_W  = 4,
    parameter int SCORE_W = 16,
    parameter int WIN_EXP = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            dir,
    input  logic [16*CELL_W-1:0]  board_in,
    output logic                  busy,
    output logic                  done,
    output logic [16*CELL_W-1:0]  board_out,
    output logic                  moved,
    output logic [SCORE_W-1:0]    score_add,
    output logic                  win
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LINE = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CELL_W-1:0] CELL_MAX = '1;

    state_t                 state_q, state_d;
    logic [1:0]             k_q;
    logic [1:0]             dir_q;
    logic [16*CELL_W-1:0]   board_q;     // accepted snapshot, used for moved
    logic [16*CELL_W-1:0]   work_q;      // board being rewritten line by line
    logic [16*CELL_W-1:0]   work_d;
    logic [SCORE_W-1:0]     score_acc_q;
    logic [SCORE_W-1:0]     score_d;
    logic [16*CELL_W-1:0]   board_out_q;
    logic                   moved_q;
    logic [SCORE_W-1:0]     score_q;
    logic                   win_q;
    logic                   moved_d;
    logic                   win_d;

    logic [CELL_W-1:0]      line_in  [4];
    logic [CELL_W-1:0]      comp     [5];  // extra slot stays empty so j+1 is always valid
    logic [CELL_W-1:0]      merged   [4];
    logic [2:0]             cnt;
    logic [1:0]             oi;
    logic                   skip;

    // Board index of position p in line k for a given direction.
    function automatic logic [3:0] cell_idx(input logic [1:0] d,
                                            input logic [1:0] k,
                                            input logic [1:0] p);
        logic [1:0] rp;
        rp = 2'd3 - p;
        case (d)
            2'b00:   return {k, p};
            2'b01:   return {k, rp};
            2'b10:   return {p, k};
            default: return {rp, k};
        endcase
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
    endfunction

    // 2^e, clipped to all-ones when it does not fit in the score width.
    function automatic logic [SCORE_W-1:0] pow2(input logic [CELL_W-1:0] e);
        if (int'(e) >= SCORE_W) return {SCORE_W{1'b1}};
        return SCORE_W'(1) << e;
    endfunction

    // ---------------- line datapath ----------------
    always_comb begin
        work_d  = work_q;
        score_d = score_acc_q;
        cnt     = 3'd0;
        oi      = 2'd0;
        skip    = 1'b0;
        for (int p = 0; p < 4; p++) begin
            line_in[p] = work_q[cell_idx(dir_q, k_q, 2'(p))*CELL_W +: CELL_W];
            merged[p]  = '0;
        end
        for (int p = 0; p < 5; p++) comp[p] = '0;

        // Compress non-empty cells toward position 0, keeping order.
        for (int p = 0; p < 4; p++) begin
            if (line_in[p] != '0) begin
                comp[cnt] = line_in[p];
                cnt       = cnt + 3'd1;
            end
        end

        // Merge pass: a merged pair consumes both cells, so skip the partner.
        for (int j = 0; j < 4; j++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (comp[j] != '0 && comp[j] == comp[j+1] && comp[j] != CELL_MAX) begin
                merged[oi] = comp[j] + 1'b1;
                score_d    = sat_add(score_d, pow2(comp[j] + 1'b1));
                skip       = 1'b1;
                oi         = oi + 2'd1;
            end else begin
                merged[oi] = comp[j];
                oi         = oi + 2'd1;
            end
        end

        for (int p = 0; p < 4; p++) begin
            work_d[cell_idx(dir_q, k_q, 2'(p))*CELL_W +: CELL_W] = merged[p];
        end
    end

    // Result flags evaluated on the board that will be published.
    always_comb begin
        moved_d = (work_d != board_q);
        win_d   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (int'(work_d[i*CELL_W +: CELL_W]) >= WIN_EXP) win_d = 1'b1;
        end
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LINE;
            S_LINE:  if (k_q == 2'd3) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= 2'd0;
            dir_q       <= 2'd0;
            board_q     <= '0;
            work_q      <= '0;
            score_acc_q <= '0;
            board_out_q <= '0;
            moved_q     <= 1'b0;
            score_q     <= '0;
            win_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        board_q     <= board_in;
                        work_q      <= board_in;
                        dir_q       <= dir;
                        score_acc_q <= '0;
                        k_q         <= 2'd0;
                    end
                end
                S_LINE: begin
                    work_q      <= work_d;
                    score_acc_q <= score_d;
                    k_q         <= k_q + 2'd1;
                    // Publish as we enter DONE so results are valid with done.
                    if (k_q == 2'd3) begin
                        board_out_q <= work_d;
                        moved_q     <= moved_d;
                        score_q     <= score_d;
                        win_q       <= win_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign board_out = board_out_q;
    assign moved     = moved_q;
    assign score_add = score_q;
    assign win       = win_q;

endmodule

// File: tb/tb_tile_merge_engine.sv
module tb_tile_merge_engine;

  localparam int CELL_W  = 4;
  localparam int SCORE_W = 16;
  localparam int WIN_EXP = 11;
  localparam int BW      = 16 * CELL_W;

  logic               clk;
  logic               rst;
  logic               start;
  logic [1:0]         dir;
  logic [BW-1:0]      board_in;
  logic               busy;
  logic               done;
  logic [BW-1:0]      board_out;
  logic               moved;
  logic [SCORE_W-1:0] score_add;
  logic               win;

  int checks = 0;
  int errors = 0;

  tile_merge_engine #(.CELL_W(CELL_W), .SCORE_W(SCORE_W), .WIN_EXP(WIN_EXP)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .board_in(board_in),
    .busy(busy), .done(done), .board_out(board_out), .moved(moved),
    .score_add(score_add), .win(win)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: lines as queues, merge by popping pairs.
  function automatic void model(input logic [BW-1:0] b, input logic [1:0] d,
                                output logic [BW-1:0] ob, output int sc,
                                output bit mv, output bit w);
    int q[$];
    int outl[$];
    int r, c, a;
    longint total;
    total = 0;
    ob = '0;
    for (int k = 0; k < 4; k++) begin
      q.delete();
      outl.delete();
      for (int p = 0; p < 4; p++) begin
        case (d)
          2'b00: begin r = k; c = p; end
          2'b01: begin r = k; c = 3 - p; end
          2'b10: begin r = p; c = k; end
          default: begin r = 3 - p; c = k; end
        endcase
        a = int'(b[(r*4+c)*CELL_W +: CELL_W]);
        if (a != 0) q.push_back(a);
      end
      while (q.size() > 0) begin
        a = q.pop_front();
        if (q.size() > 0 && q[0] == a && a != (1 << CELL_W) - 1) begin
          void'(q.pop_front());
          outl.push_back(a + 1);
          total += longint'(1) << (a + 1);
        end else begin
          outl.push_back(a);
        end
      end
      while (outl.size() < 4) outl.push_back(0);
      for (int p = 0; p < 4; p++) begin
        case (d)
          2'b00: begin r = k; c = p; end
          2'b01: begin r = k; c = 3 - p; end
          2'b10: begin r = p; c = k; end
          default: begin r = 3 - p; c = k; end
        endcase
        ob[(r*4+c)*CELL_W +: CELL_W] = CELL_W'(outl[p]);
      end
    end
    sc = (total > (1 << SCORE_W) - 1) ? (1 << SCORE_W) - 1 : int'(total);
    mv = (ob != b);
    w = 1'b0;
    for (int i = 0; i < 16; i++)
      if (int'(ob[i*CELL_W +: CELL_W]) >= WIN_EXP) w = 1'b1;
  endfunction

  // ---------------- driver ----------------
  task automatic do_move(input logic [BW-1:0] b, input logic [1:0] d, input string tag);
    logic [BW-1:0] eb;
    int esc;
    bit emv, ew;
    int lat;
    model(b, d, eb, esc, emv, ew);
    exp_q.push_back(eb);
    @(negedge clk);
    board_in = b;
    dir = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".busy_after_accept"}, BW'(busy), BW'(1));
    @(negedge clk);
    start = 1'b0;
    board_in = '0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, BW'(lat), BW'(5));
    check({tag, ".busy_at_done"}, BW'(busy), BW'(1));
    check({tag, ".board_out"}, board_out, exp_q.pop_front());
    check({tag, ".moved"}, BW'(moved), BW'(emv));
    check({tag, ".score_add"}, BW'(score_add), BW'(esc));
    check({tag, ".win"}, BW'(win), BW'(ew));
    @(negedge clk);
    check({tag, ".done_one_cycle"}, BW'(done), BW'(0));
    check({tag, ".idle_after"}, BW'(busy), BW'(0));
    check({tag, ".board_hold"}, board_out, eb);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [BW-1:0] rb;
    logic [BW-1:0] eb;
    int esc;
    bit emv, ew;
    int done_cyc[$];
    int nd;

    rst = 1'b1;
    start = 1'b0;
    dir = 2'b00;
    board_in = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", BW'(busy), BW'(0));
    check("reset.done", BW'(done), BW'(0));
    check("reset.board_out", board_out, '0);
    check("reset.moved", BW'(moved), BW'(0));
    check("reset.score_add", BW'(score_add), BW'(0));
    check("reset.win", BW'(win), BW'(0));
    rst = 1'b0;

    // Directed moves
    do_move(64'h1111, 2'b00, "left_1111");
    check("left_1111.row0", board_out, 64'h0022);
    check("left_1111.score", BW'(score_add), BW'(8));
    do_move(64'h0112, 2'b01, "right_2110");
    check("right_2110.row0", board_out, 64'h2200);
    check("right_2110.score", BW'(score_add), BW'(4));
    do_move(64'h0000_0000_000A_000A, 2'b10, "up_win");
    check("up_win.board", board_out, 64'h000B);
    check("up_win.score", BW'(score_add), BW'(2048));
    check("up_win.win", BW'(win), BW'(1));
    do_move(64'h1234_4321_1234_4321, 2'b00, "left_blocked");
    check("left_blocked.same", board_out, 64'h1234_4321_1234_4321);
    do_move(64'h0, 2'b11, "empty_down");
    do_move(64'h00FF, 2'b00, "max_no_merge");
    check("max_no_merge.board", board_out, 64'h00FF);
    do_move(64'h2121, 2'b00, "alt_unchanged");
    do_move(64'h2101, 2'b00, "gap_merge");
    check("gap_merge.board", board_out, 64'h0022);
    do_move(64'hEEEE_EEEE_EEEE_EEEE, 2'b01, "score_sat");

    // Start held high: accepts at T, T+6, T+12
    rb = 64'h0000_1100_0022_0011;
    model(rb, 2'b00, eb, esc, emv, ew);
    @(negedge clk);
    board_in = rb;
    dir = 2'b00;
    start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_cyc.push_back(cyc);
        check($sformatf("held.board_%0d", cyc), board_out, eb);
      end
    end
    start = 1'b0;
    nd = done_cyc.size();
    check("held.done_count", BW'(nd), BW'(3));
    if (nd == 3) begin
      check("held.done0", BW'(done_cyc[0]), BW'(5));
      check("held.done1", BW'(done_cyc[1]), BW'(11));
      check("held.done2", BW'(done_cyc[2]), BW'(17));
    end
    repeat (2) @(negedge clk);
    check("held.idle", BW'(busy), BW'(0));

    // Reset in the middle of a move
    @(negedge clk);
    board_in = 64'h1111_2222;
    dir = 2'b00;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst.busy", BW'(busy), BW'(0));
    check("midrst.done", BW'(done), BW'(0));
    check("midrst.board_out", board_out, '0);
    check("midrst.moved", BW'(moved), BW'(0));
    check("midrst.score_add", BW'(score_add), BW'(0));
    check("midrst.win", BW'(win), BW'(0));
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("midrst.no_done", BW'(nd), BW'(0));
    do_move(64'h0000_0000_0000_3300, 2'b00, "after_rst");

    // Randomized moves against the model
    for (int it = 0; it < 40; it++) begin
      rb = '0;
      for (int i = 0; i < 16; i++) begin
        if (it % 4 == 0) rb[i*CELL_W +: CELL_W] = CELL_W'($urandom_range(0, 15));
        else rb[i*CELL_W +: CELL_W] = CELL_W'($urandom_range(0, 3));
      end
      do_move(rb, 2'($urandom_range(0, 3)), $sformatf("rand%0d", it));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_merge_engine.md
TILE_MERGE_ENGINE -- requirements
Module: tile_merge_engine

Interface
REQ-001 SHALL have parameter CELL_W, default 4: width of one cell exponent; 0 = empty, e = tile value 2^e.
REQ-002 SHALL have parameter SCORE_W, default 16: width of score_add.
REQ-003 SHALL have parameter WIN_EXP, default 11: exponent that counts as a win (2048).
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1: request a move; accepted only when busy=0.
REQ-007 SHALL have port dir, input, 2: move direction; 00 left, 01 right, 10 up, 11 down.
REQ-008 SHALL have port board_in, input, 16*CELL_W: board snapshot; cell (r,c) at index i=r*4+c, bits [i*CELL_W +: CELL_W].
REQ-009 SHALL have port busy, output, 1: move in progress.
REQ-010 SHALL have port done, output, 1: one-cycle pulse; result valid.
REQ-011 SHALL have port board_out, output, 16*CELL_W: resulting board, same packing as board_in.
REQ-012 SHALL have port moved, output, 1: board_out differs from the accepted board_in (consumed by tile spawner).
REQ-013 SHALL have port score_add, output, SCORE_W: score gained by this move.
REQ-014 SHALL have port win, output, 1: any board_out cell >= WIN_EXP.

Function
REQ-015 SHALL use FSM states IDLE, LINE, DONE; LINE holds a 2-bit line counter k.
REQ-016 IDLE: start=1 in cycle T SHALL register board_in and dir, clear accumulators, set k=0, and enter LINE; busy=1 from T+1.
REQ-017 LINE SHALL process exactly one line per cycle, k=0..3, in cycles T+1..T+4; it SHALL then enter DONE.
REQ-018 DONE (cycle T+5) SHALL assert done=1 for exactly one cycle with busy=1, then return to IDLE with busy=0.
REQ-019 board_out, moved, score_add and win SHALL update only at DONE and hold stable until the next DONE.
REQ-020 start while busy=1 SHALL be ignored; no queuing.
REQ-021 Line k element order (position 0 first): left (k,0..3); right (k,3..0); up (0..3,k); down (3..0,k).
REQ-022 Each line SHALL compress non-empty cells toward position 0, preserving order, with empties filled at the far end.
REQ-023 Merge: scanning from position 0, two adjacent compressed equal cells e SHALL become one cell e+1, and each cell SHALL merge at most once per move.
REQ-024 Merge examples: [1,1,1,1]->[2,2,0,0]; [2,1,1,0]->[2,2,0,0]; [1,0,1,2]->[2,2,0,0]; [1,2,1,2]->unchanged.
REQ-025 Cells equal to 2^CELL_W-1 SHALL NOT merge; exponent saturation SHALL never wrap.
REQ-026 Each merge producing e+1 SHALL add 2^(e+1) to score_add; the sum SHALL saturate at all-ones and never wrap.
REQ-027 moved SHALL be 1 iff any of the 16 output cells differs from the registered input.
REQ-028 An empty board or a blocked board SHALL produce moved=0, score_add=0, and board_out equal to board_in.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE with busy=0, done=0, board_out=0, moved=0, score_add=0, win=0, and k=0.
REQ-030 rst asserted mid-move SHALL abort the move; no done pulse; the partial result SHALL be discarded.
REQ-031 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-032 Left, row0=[1,1,1,1] (2,2,2,2), rest empty -> done at T+5; row0=[2,2,0,0]; moved=1; score_add=8.
REQ-033 Right, row0=[2,1,1,0] -> row0=[0,0,2,2]; score_add=4; moved=1.
REQ-034 Up, column0 top-to-bottom=[10,10,0,0] -> (0,0)=11, others 0; score_add=2048; win=1.
REQ-035 Left, board already packed with no equal neighbours -> moved=0; score_add=0; board_out==board_in; done pulses once.
REQ-036 start held high continuously -> moves accepted at T, T+6, T+12; exactly one done per move.
REQ-037 rst at T+2 of a move -> busy=0 and all outputs 0 immediately; no done; the next start completes normally.
